// File: rtl/wb_mem_responder.sv
// ---------------------------------------------------------------------------
// wb_mem_responder
//
// Wishbone-classic responder that stands in for the DRAM wrapper's user-side
// interface, backed by on-chip block RAM. After reset it zero-fills the whole
// array, raises `initialized`, and then serves one read or write at a time
// with fixed, configurable read and write latencies.
//
// Handshake: a request is accepted on a posedge where the FSM is IDLE and
// cyc_i & stb_i is high. we_i, the word index and data_i are captured at that
// edge. ack_o is a one-cycle pulse; for reads data_o is valid with ack_o and
// is then held until the next read completes. Dropping cyc_i while the access
// is pending abandons it: no ack and no memory write.
//
// Ports:
//   sys_clk      in   1          single clock, posedge
//   rst_n        in   1          synchronous active-low reset
//   initialized  out  1          zero-fill complete (stays high until reset)
//   cyc_i        in   1          Wishbone cycle
//   stb_i        in   1          Wishbone strobe
//   we_i         in   1          1 = write, 0 = read
//   addr_i       in   32         byte address, word index at [ADDR_LSB +: log2(DEPTH)]
//   data_i       in   WORD_SIZE  write data
//   data_o       out  WORD_SIZE  read data, held between reads
//   ack_o        out  1          single-cycle acknowledge
//   dbg_state_o  out  2          current FSM state (INIT=0, IDLE=1, BUSY=2, ACK=3)
// ---------------------------------------------------------------------------
module wb_mem_responder #(
  parameter int WORD_SIZE     = 256,
  parameter int DEPTH         = 64,
  parameter int ADDR_LSB      = 7,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  output logic                 initialized,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 ack_o,
  output logic [1:0]           dbg_state_o
);

  localparam int AW      = $clog2(DEPTH);
  // Fill index runs 0..DEPTH: values below DEPTH write a word, DEPTH is the
  // extra cycle in which the FSM leaves INIT.
  localparam int FW      = AW + 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [FW-1:0] FILL_END = FW'(DEPTH);
  localparam logic [CW-1:0] RD_LOAD  = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD  = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // State and datapath registers
  state_t               r_state;
  logic [FW-1:0]        r_fill;
  logic [CW-1:0]        r_cnt;
  logic                 r_we;
  logic [AW-1:0]        r_idx;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_data_o;
  logic                 r_ack;
  logic                 r_init;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  // Combinational signals
  state_t               w_next_state;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_fill_done;
  logic [AW-1:0]        w_addr_idx;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [WORD_SIZE-1:0] w_mem_wdata;
  logic                 w_unused_addr;

  assign w_req       = cyc_i & stb_i;
  assign w_accept    = (r_state == S_IDLE) && w_req;
  assign w_fill_done = (r_fill == FILL_END);
  assign w_addr_idx  = addr_i[ADDR_LSB +: AW];
  // Bits outside the word-index field are deliberately ignored (aliasing).
  assign w_unused_addr = ^addr_i;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and the single memory write port. The zero-fill and user
  // writes share one port so the array maps onto a simple-dual-port RAM.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_idx;
    w_mem_wdata  = r_wdata;
    case (r_state)
      S_INIT: begin
        if (w_fill_done) begin
          w_next_state = S_IDLE;
        end else begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_fill[AW-1:0];
          w_mem_wdata = '0;
        end
      end
      S_IDLE: begin
        if (w_req) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        // Abort has priority over completion, so a dropped cycle never
        // commits a write even on the final latency cycle.
        if (!cyc_i) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == '0) begin
          w_next_state = S_ACK;
          w_mem_we     = r_we;
        end
      end
      S_ACK: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_INIT;
      end
    endcase
    // A reset edge must never commit a pending write.
    if (!rst_n) begin
      w_mem_we = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Request capture. Fields are only meaningful while BUSY, so they carry
  // no reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst_n && w_accept) begin
      r_we    <= we_i;
      r_idx   <= w_addr_idx;
      r_wdata <= data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Fill index, latency counter, ack, read data, initialized flag
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_init   <= 1'b0;
      r_ack    <= 1'b0;
      r_data_o <= '0;
      r_fill   <= '0;
      r_cnt    <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (w_fill_done) begin
            r_init <= 1'b1;
          end else begin
            r_fill <= r_fill + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_req) begin
            r_cnt <= we_i ? WR_LOAD : RD_LOAD;
          end
        end
        S_BUSY: begin
          if (cyc_i) begin
            if (r_cnt == '0) begin
              r_ack <= 1'b1;
              if (!r_we) begin
                r_data_o <= r_mem[r_idx];
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage array (contents survive reset; the zero-fill clears them)
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign initialized = r_init;
  assign ack_o       = r_ack;
  assign data_o      = r_data_o;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_responder
//
// Directed bench for wb_mem_responder with default parameters
// (WORD_SIZE=256, DEPTH=64, ADDR_LSB=7, READ_LATENCY=4, WRITE_LATENCY=2).
// Inputs change on the negedge; outputs are sampled 1 ns after the posedge.
// ---------------------------------------------------------------------------
module tb_wb_mem_responder;

  localparam int W = 256;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;

  localparam logic [W-1:0] D1     = {2{128'hAABBCCDDEEFF00112233445566778899}};
  localparam logic [W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [W-1:0] PAT_5A = {32{8'h5A}};
  localparam logic [W-1:0] PAT_77 = {32{8'h77}};
  localparam logic [W-1:0] PAT_11 = {32{8'h11}};
  localparam logic [W-1:0] ZERO   = '0;
  localparam logic [W-1:0] ONES   = '1;

  // Clock / reset / DUT signals
  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic         initialized;
  logic         cyc_i   = 1'b0;
  logic         stb_i   = 1'b0;
  logic         we_i    = 1'b0;
  logic [31:0]  addr_i  = '0;
  logic [W-1:0] data_i  = '0;
  logic [W-1:0] data_o;
  logic         ack_o;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_mem_responder dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .initialized (initialized),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .dbg_state_o (dbg_state_o)
  );

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Driver: one complete transaction from IDLE. Inputs are scrambled right
  // after the accept edge so that any failure to latch shows up. Returns the
  // number of edges from accept to the first ack sample, and ack_o one cycle
  // after that.
  // -------------------------------------------------------------------------
  task automatic do_xfer(input logic we, input logic [31:0] addr,
                         input logic [W-1:0] wdata,
                         output int lat, output logic ack_after);
    @(negedge sys_clk);
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    data_i = wdata;
    @(posedge sys_clk);
    #1;
    we_i   = ~we;
    addr_i = addr ^ 32'h0000_0F80;
    data_i = ~wdata;
    lat = 0;
    do begin
      @(posedge sys_clk);
      #1;
      lat++;
    end while (ack_o !== 1'b1 && lat < 50);
    @(negedge sys_clk);
    cyc_i  = 1'b0;
    stb_i  = 1'b0;
    we_i   = 1'b0;
    data_i = '0;
    @(posedge sys_clk);
    #1;
    ack_after = ack_o;
  endtask

  // Waits for initialized after rst_n is released on a negedge; returns the
  // edge count and whether ack_o was seen before initialized.
  task automatic release_and_wait_init(output int n, output logic early_ack);
    @(negedge sys_clk);
    rst_n = 1'b1;
    n = 0;
    early_ack = 1'b0;
    do begin
      @(posedge sys_clk);
      #1;
      n++;
      if (ack_o !== 1'b0 && initialized !== 1'b1) early_ack = 1'b1;
    end while (initialized !== 1'b1 && n < 200);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    int   n;
    logic early;
    int   lat;
    logic aa;
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (initialized !== 1'b0) begin errors++; $display("FAIL reset_initialized: got %b expected 0", initialized); end
    checks++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL reset_data: got %h expected %h", data_o, ZERO); end
    checks++;
    if (dbg_state_o !== ST_INIT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, ST_INIT); end

    release_and_wait_init(n, early);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL init_cycles: got %0d expected 65", n); end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL init_no_ack: got %b expected 0", early); end
    checks++;
    if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL init_state_idle: got %0d expected %0d", dbg_state_o, ST_IDLE); end

    do_xfer(1'b0, 32'd5 << 7, ONES, lat, aa);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL read5_latency: got %0d expected 4", lat); end
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL read5_zero: got %h expected %h", data_o, ZERO); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write_read();
    int   lat;
    logic aa;
    do_xfer(1'b1, 32'h0000_0080, D1, lat, aa);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write1_latency: got %0d expected 2", lat); end
    checks++;
    if (aa !== 1'b0) begin errors++; $display("FAIL write1_ack_width: got %b expected 0", aa); end
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL write1_data_held: got %h expected %h", data_o, ZERO); end

    do_xfer(1'b0, 32'h0000_0080, ZERO, lat, aa);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL read1_latency: got %0d expected 4", lat); end
    checks++;
    if (aa !== 1'b0) begin errors++; $display("FAIL read1_ack_width: got %b expected 0", aa); end
    checks++;
    if (data_o !== D1) begin errors++; $display("FAIL read1_data: got %h expected %h", data_o, D1); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_alias();
    int   lat;
    logic aa;
    do_xfer(1'b1, 32'h0000_0000, PAT_A5, lat, aa);
    do_xfer(1'b0, 32'd64 << 7, ZERO, lat, aa);
    checks++;
    if (data_o !== PAT_A5) begin errors++; $display("FAIL alias_word0: got %h expected %h", data_o, PAT_A5); end
    // Low byte bits and a high address bit set: still word 1.
    do_xfer(1'b0, 32'h8000_00FF, ZERO, lat, aa);
    checks++;
    if (data_o !== D1) begin errors++; $display("FAIL alias_lowbits: got %h expected %h", data_o, D1); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_abort();
    int   lat;
    logic aa;
    logic seen;
    // Read abort: data_o currently holds D1.
    seen = 1'b0;
    @(negedge sys_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
    @(posedge sys_clk);                         // accept
    repeat (2) begin @(posedge sys_clk); #1; if (ack_o !== 1'b0) seen = 1'b1; end
    @(negedge sys_clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (10) begin @(posedge sys_clk); #1; if (ack_o !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_read_no_ack: got %b expected 0", seen); end
    checks++;
    if (data_o !== D1) begin errors++; $display("FAIL abort_read_data_held: got %h expected %h", data_o, D1); end
    checks++;
    if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dbg_state_o, ST_IDLE); end

    // Write abort on the last latency cycle: word 0 must keep PAT_A5.
    seen = 1'b0;
    @(negedge sys_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; data_i = ONES;
    @(posedge sys_clk);                         // accept
    @(posedge sys_clk); #1; if (ack_o !== 1'b0) seen = 1'b1;
    @(negedge sys_clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; data_i = '0;
    repeat (6) begin @(posedge sys_clk); #1; if (ack_o !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_write_no_ack: got %b expected 0", seen); end

    do_xfer(1'b0, 32'h0, ZERO, lat, aa);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL after_abort_latency: got %0d expected 4", lat); end
    checks++;
    if (data_o !== PAT_A5) begin errors++; $display("FAIL after_abort_data: got %h expected %h", data_o, PAT_A5); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    int n;
    int gap;
    @(negedge sys_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 32'd3 << 7; data_i = PAT_5A;
    @(posedge sys_clk);                         // accept write
    n = 0;
    do begin @(posedge sys_clk); #1; n++; end while (ack_o !== 1'b1 && n < 50);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL b2b_write_latency: got %0d expected 2", n); end
    @(negedge sys_clk);
    we_i = 1'b0; data_i = '0;                   // cyc/stb stay high
    gap = 0;
    do begin
      @(posedge sys_clk); #1;
      if (ack_o !== 1'b1) gap++;
    end while (ack_o !== 1'b1 && gap < 50);
    checks++;
    if (gap !== 5) begin errors++; $display("FAIL b2b_ack_gap: got %0d expected 5", gap); end
    checks++;
    if (data_o !== PAT_5A) begin errors++; $display("FAIL b2b_read_data: got %h expected %h", data_o, PAT_5A); end
    @(negedge sys_clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL b2b_ack_single: got %b expected 0", ack_o); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_init_request_and_reset();
    int   n;
    int   lat;
    logic early;
    logic aa;
    logic bad_rst;
    // Request held through the whole zero-fill.
    @(negedge sys_clk);
    rst_n = 1'b0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 32'd4 << 7; data_i = PAT_77;
    repeat (2) @(posedge sys_clk);
    release_and_wait_init(n, early);
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL init_req_no_ack: got %b expected 0", early); end
    checks++;
    if (n !== 65) begin errors++; $display("FAIL init_req_cycles: got %0d expected 65", n); end
    n = 0;
    do begin @(posedge sys_clk); #1; n++; end while (ack_o !== 1'b1 && n < 50);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL init_req_ack_delay: got %0d expected 3", n); end
    @(negedge sys_clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; data_i = '0;
    do_xfer(1'b0, 32'd4 << 7, ZERO, lat, aa);
    checks++;
    if (data_o !== PAT_77) begin errors++; $display("FAIL init_req_written: got %h expected %h", data_o, PAT_77); end

    // Reset in the middle of a write to word 6.
    @(negedge sys_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 32'd6 << 7; data_i = PAT_11;
    @(posedge sys_clk);                         // accept
    @(negedge sys_clk);
    rst_n = 1'b0;
    bad_rst = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL midreset_data: got %h expected %h", data_o, ZERO); end
    checks++;
    if (dbg_state_o !== ST_INIT) begin errors++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state_o, ST_INIT); end
    if (ack_o !== 1'b0 || initialized !== 1'b0) bad_rst = 1'b1;
    @(negedge sys_clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; data_i = '0;
    @(posedge sys_clk); #1;
    if (ack_o !== 1'b0 || initialized !== 1'b0) bad_rst = 1'b1;
    checks++;
    if (bad_rst !== 1'b0) begin errors++; $display("FAIL midreset_ack_init_low: got %b expected 0", bad_rst); end
    release_and_wait_init(n, early);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL refill_cycles: got %0d expected 65", n); end
    do_xfer(1'b0, 32'd6 << 7, ONES, lat, aa);
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL refill_word6: got %h expected %h", data_o, ZERO); end
    do_xfer(1'b1, 32'd2 << 7, PAT_11, lat, aa);
    do_xfer(1'b0, 32'd4 << 7, ONES, lat, aa);
    checks++;
    if (data_o !== ZERO) begin errors++; $display("FAIL refill_word4: got %h expected %h", data_o, ZERO); end
    do_xfer(1'b0, 32'd2 << 7, ZERO, lat, aa);
    checks++;
    if (data_o !== PAT_11) begin errors++; $display("FAIL post_refill_rw: got %h expected %h", data_o, PAT_11); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_abort();
    test_back_to_back();
    test_init_request_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
